// File: rtl/regfile_mp.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : regfile_mp
// Function : Multi-port register file. Two write ports, two registered read
//            ports with valid pulses, optional hardwired-zero entry 0 and a
//            write-collision flag. Define REGFILE_BYPASS_EN to forward
//            same-edge write data to the read ports.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 19,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              wconflict
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < c_DEPTH);
    endfunction

    function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write is "effective" only if it will actually land in an entry.
    logic w_wr0_ok;
    logic w_wr1_ok;
    logic w_conflict;

    assign w_wr0_ok   = we0 && addr_in_range(waddr0) && !addr_is_zero_reg(waddr0);
    assign w_wr1_ok   = we1 && addr_in_range(waddr1) && !addr_is_zero_reg(waddr1);
    assign w_conflict = w_wr0_ok && w_wr1_ok && (waddr0 == waddr1);

    logic [DATA_W-1:0] w_entry [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign w_entry[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] entry_q;
                logic [DATA_W-1:0] entry_d;
                logic              w_hit0;
                logic              w_hit1;

                assign w_hit0 = w_wr0_ok && (waddr0 == ADDR_W'(gi));
                assign w_hit1 = w_wr1_ok && (waddr1 == ADDR_W'(gi));

                // Port 1 has priority on a collision.
                always_comb begin
                    entry_d = entry_q;
                    if (w_hit1) begin
                        entry_d = wdata1;
                    end else if (w_hit0) begin
                        entry_d = wdata0;
                    end
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        entry_q <= '0;
                    end else begin
                        entry_q <= entry_d;
                    end
                end

                assign w_entry[gi] = entry_q;
            end
        end
    endgenerate

    // Unmatched (out-of-range) addresses fall through to zero.
    function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                val = w_entry[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr1_ok && (waddr1 == addr)) begin
            val = wdata1;
        end else if (w_wr0_ok && (waddr0 == addr)) begin
            val = wdata0;
        end
`endif
        return val;
    endfunction

    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic              wconflict_q, wconflict_d;

    always_comb begin
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        rvalid_a_d  = re_a;
        rvalid_b_d  = re_b;
        wconflict_d = w_conflict;
        if (re_a) begin
            rdata_a_d = lookup(raddr_a);
        end
        if (re_b) begin
            rdata_b_d = lookup(raddr_b);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            wconflict_q <= 1'b0;
        end else begin
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            rvalid_a_q  <= rvalid_a_d;
            rvalid_b_q  <= rvalid_b_d;
            wconflict_q <= wconflict_d;
        end
    end

    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign wconflict = wconflict_q;

endmodule
`default_nettype wire
